// File: rtl/mvau_wctrl_pkg.sv
// Shared constants and helpers for the MVAU weight-memory read sequencer.
// FSM state encodings, fold-count arithmetic and counter-width sizing.
package mvau_wctrl_pkg;

    typedef logic [1:0] wctrl_state_t;

    localparam wctrl_state_t ST_IDLE  = 2'd0;
    localparam wctrl_state_t ST_RUN   = 2'd1;
    localparam wctrl_state_t ST_DRAIN = 2'd2;

    function automatic int calc_sf(input int mw, input int simd);
        return mw / simd;
    endfunction

    function automatic int calc_nf(input int mh, input int pe);
        return mh / pe;
    endfunction

    function automatic int calc_total(input int sf, input int nf, input int num_pix);
        return sf * nf * num_pix;
    endfunction

    // A counter over a single value still needs one bit of storage.
    function automatic int cnt_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_wctrl_fold_cnt.sv
// Wrap-around fold counter: counts 0..N-1 on inc, returns to 0 after N-1.
// at_max flags the last value so callers can chain counters.
module mvau_wctrl_fold_cnt #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         at_max
);

    logic [W-1:0] value_q, value_d;

    assign at_max = (value_q == W'(N - 1));
    assign value  = value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = at_max ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/mvau_wmem_ctrl.sv
// Weight-memory read sequencer for one MVAU PE: issues nf->sf fold addresses per pixel.
// Define MVAU_WCTRL_PERF_EN to add the stall_cnt performance counter output.
module mvau_wmem_ctrl
    import mvau_wctrl_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int MW           = 4,
    parameter int MH           = 2,
    parameter int PE           = 1,
    parameter int NUM_PIX      = 4,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                      aclk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_v,
    output logic                      in_rdy,
    output logic [WMEM_ADDR_BW-1:0]   wmem_addr,
    input  logic                      out_rdy,
    output logic                      w_valid,
    output logic                      w_sf_first,
    output logic                      w_sf_last,
    output logic [$clog2(MH/PE):0]    w_nf_idx,
    output logic                      busy,
    output logic                      done
`ifdef MVAU_WCTRL_PERF_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int SF       = calc_sf(MW, SIMD);
    localparam int NF       = calc_nf(MH, PE);
    localparam int SF_W     = cnt_bw(SF);
    localparam int NF_W     = cnt_bw(NF);
    localparam int PIX_W    = cnt_bw(NUM_PIX);
    localparam int NF_IDX_W = $clog2(NF) + 1;

    if (MW % SIMD != 0) begin : g_chk_mw
        $error("mvau_wmem_ctrl: MW must be a multiple of SIMD");
    end
    if (MH % PE != 0) begin : g_chk_mh
        $error("mvau_wmem_ctrl: MH must be a multiple of PE");
    end
    if (WMEM_DEPTH != SF * NF) begin : g_chk_depth
        $error("mvau_wmem_ctrl: WMEM_DEPTH must equal SF*NF");
    end
    if (WMEM_ADDR_BW < $clog2(WMEM_DEPTH)) begin : g_chk_abw
        $error("mvau_wmem_ctrl: WMEM_ADDR_BW too narrow for WMEM_DEPTH");
    end
    if (calc_total(SF, NF, NUM_PIX) < 1) begin : g_chk_total
        $error("mvau_wmem_ctrl: frame must contain at least one word");
    end

    wctrl_state_t              state_q, state_d;
    logic [WMEM_ADDR_BW-1:0]   addr_q, addr_d, addr_prev_q, addr_prev_d;
    logic                      w_valid_q, w_valid_d;
    logic                      sf_first_q, sf_first_d, sf_last_q, sf_last_d;
    logic [NF_IDX_W-1:0]       nf_idx_q, nf_idx_d;

    logic [SF_W-1:0]           sf_val;
    logic [NF_W-1:0]           nf_val;
    logic [PIX_W-1:0]          pix_val_unused;
    logic                      sf_max, nf_max, pix_max;
    logic                      start_acc, advance, sf_wrap, nf_wrap, last_issue, drain_done;

    assign start_acc  = (state_q == ST_IDLE) & start;
    assign in_rdy     = (state_q == ST_RUN) & (~w_valid_q | out_rdy);
    assign advance    = in_v & in_rdy;
    assign sf_wrap    = advance & sf_max;
    assign nf_wrap    = sf_wrap & nf_max;
    assign last_issue = nf_wrap & pix_max;
    assign drain_done = (state_q == ST_DRAIN) & w_valid_q & out_rdy;

    mvau_wctrl_fold_cnt #(.N(SF), .W(SF_W)) u_sf_cnt (
        .clk(aclk), .rst(rst), .clr(start_acc), .inc(advance),
        .value(sf_val), .at_max(sf_max)
    );

    mvau_wctrl_fold_cnt #(.N(NF), .W(NF_W)) u_nf_cnt (
        .clk(aclk), .rst(rst), .clr(start_acc), .inc(sf_wrap),
        .value(nf_val), .at_max(nf_max)
    );

    mvau_wctrl_fold_cnt #(.N(NUM_PIX), .W(PIX_W)) u_pix_cnt (
        .clk(aclk), .rst(rst), .clr(start_acc), .inc(nf_wrap),
        .value(pix_val_unused), .at_max(pix_max)
    );

    // Memory read is unconditional, so a stalled word is held by re-reading its address.
    assign wmem_addr  = advance ? addr_q : addr_prev_q;
    assign w_valid    = w_valid_q;
    assign w_sf_first = sf_first_q;
    assign w_sf_last  = sf_last_q;
    assign w_nf_idx   = nf_idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = drain_done;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        addr_prev_d = addr_prev_q;
        sf_first_d  = sf_first_q;
        sf_last_d   = sf_last_q;
        nf_idx_d    = nf_idx_q;
        w_valid_d   = advance | (w_valid_q & ~out_rdy);

        case (state_q)
            ST_IDLE:  if (start)      state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase

        if (start_acc) begin
            addr_d = '0;
        end else if (advance) begin
            addr_prev_d = addr_q;
            addr_d      = (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
            sf_first_d  = (sf_val == '0);
            sf_last_d   = sf_max;
            nf_idx_d    = NF_IDX_W'(nf_val);
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            addr_prev_q <= '0;
            w_valid_q   <= 1'b0;
            sf_first_q  <= 1'b0;
            sf_last_q   <= 1'b0;
            nf_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            addr_prev_q <= addr_prev_d;
            w_valid_q   <= w_valid_d;
            sf_first_q  <= sf_first_d;
            sf_last_q   <= sf_last_d;
            nf_idx_q    <= nf_idx_d;
        end
    end

`ifdef MVAU_WCTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_ev;

    // Either the PE is back-pressuring us or we are starved of activations.
    assign stall_ev  = (state_q != ST_IDLE) & ((w_valid_q & ~out_rdy) | (in_rdy & ~in_v));
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if (stall_ev && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
